sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO. It succeeds the fixed 16x8 FIFO with configurable width and depth, runtime-programmable almost-full and almost-empty thresholds, and an occupancy output. It accepts a simultaneous read and write when full. It sits between a producer/consumer pair inside one clock domain, and its flag set is a superset of the earlier FIFO's.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries; power of two, >=2
ADDR_W, $clog2(FIFO_DEPTH), derived localparam, pointer width; occupancy width is ADDR_W+1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
wr_en  in  1  write request
rd_en  in  1  read request
data_in  in  FIFO_WIDTH  write data
af_thresh  in  ADDR_W+1  almost-full threshold, quasi-static
ae_thresh  in  ADDR_W+1  almost-empty threshold, quasi-static
data_out  out  FIFO_WIDTH  read data
wr_ack  out  1  registered; previous-cycle write accepted
overflow  out  1  registered; previous-cycle write rejected
underflow  out  1  registered; previous-cycle read rejected
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= af_thresh && count != FIFO_DEPTH
almostempty  out  1  count <= ae_thresh && count != 0
count  out  ADDR_W+1  current occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. Flags follow count, so empty=1, full=0, almostfull=0, almostempty=0. Memory contents are not reset.
- Reset mid-operation: takes effect immediately, with no clock edge required. In-flight data is discarded. Operation resumes on the first rising edge after rst deasserts.
- Write accept (wa): wr_en && (!full || rd_en). On wa, mem[wr_ptr] <= data_in, wr_ptr increments modulo FIFO_DEPTH, and wr_ack=1 next cycle.
- Read accept (ra): rd_en && !empty. On ra, rd_ptr increments modulo FIFO_DEPTH.
- Rejected write: wr_en && !wa gives overflow=1 next cycle and wr_ack=0.
- Rejected read: rd_en && empty gives underflow=1 next cycle.
- All three status pulses (wr_ack, overflow, underflow) are recomputed every cycle and are not sticky.
- Count update: count <= count + wa - ra. It never exceeds FIFO_DEPTH and never goes below 0.
- Empty with rd_en && wr_en: only the write occurs. count +1, underflow=1, data_out holds.
- Full with rd_en && wr_en: both occur. count holds, wr_ack=1, overflow=0. This is new versus the predecessor, which performed the read only.
- Read data timing: data_out <= mem[rd_ptr] on ra (1-cycle latency). data_out holds its value otherwise.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. full/empty derive from count, never from pointer comparison.
- Threshold out of range: af_thresh > FIFO_DEPTH means almostfull is never asserted. ae_thresh = 0 means almostempty is never asserted.
- Flag timing: flags are combinational from the registered count, so they reflect the state after the last edge.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word fall-through): data_out continuously shows mem[rd_ptr] whenever !empty, with zero read latency. rd_en acknowledges and pops the word. A word written into an empty FIFO appears on data_out the cycle after its write. data_out is 0 while empty.
- Undefined: standard 1-cycle registered read as described under Behaviour.
- Both modes: count and flag behaviour are identical.

Test Plan:
1. Reset during traffic. Assert rst with count=5 -> same delta: count=0, empty=1, wr_ack=overflow=underflow=0, data_out=0, without waiting for clk.
2. Fill and overflow. DEPTH=8, af_thresh=6, ae_thresh=2; write 0x0001..0x0009 -> almostempty high at counts 1-2, almostfull at 6-7, full at 8. The 9th write gives overflow=1, wr_ack=0, count stays 8.
3. Full with rd_en && wr_en, data_in=0xBEEF -> count stays 8, wr_ack=1, overflow=0, data_out=0x0001. Drain all 8 -> 0x0002..0x0008 then 0xBEEF in order.
4. Empty with rd_en && wr_en, data_in=0x00A5 -> underflow=1, count=1, data_out unchanged. Next read returns 0x00A5.
5. Wrap-around. Interleave 20 write/read pairs at count=3 -> FIFO order preserved across pointer wrap, count constant at 3.
6. FIFO_FWFT_EN defined. Write 0x1234 into empty -> data_out=0x1234 next cycle with no rd_en. rd_en pops it -> empty=1, data_out=0.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with runtime almost-full/almost-empty thresholds
// and an occupancy output. Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [ADDR_W:0]       af_thresh,
  input  logic [ADDR_W:0]       ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wa;
  logic                  ra;

  // Handshake: wr_en/rd_en are single-cycle requests sampled at the rising edge.
  // A write is taken when not full, or when full but a read frees a slot in the
  // same edge; a read is taken when not empty. Outcomes are reported one cycle
  // later on wr_ack/overflow/underflow, which are never sticky.
  assign wa = wr_en && (!full || rd_en);
  assign ra = rd_en && !empty;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh) && !full;
  assign almostempty = (count <= ae_thresh) && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wa;
      overflow  <= wr_en && !wa;
      underflow <= rd_en && empty;
      if (wa) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ra) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wa, ra})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (ra) begin
      rd_data <= mem[rd_ptr];
    end
  end

  assign data_out = rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog (16x8): table-driven vectors plus hand sequences,
// with a queue scoreboard for read data and a small occupancy model.
module tb_sync_fifo_prog;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_in;
  logic [3:0]  af_thresh;
  logic [3:0]  ae_thresh;
  logic [15:0] data_out;
  logic        wr_ack;
  logic        overflow;
  logic        underflow;
  logic        full;
  logic        empty;
  logic        almostfull;
  logic        almostempty;
  logic [3:0]  count;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .count(count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    int          cnt;
    logic        ack;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          m_cnt;
  logic [15:0] exp_dout;
  int          n_vec;
  int          n_miss;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] din,
                              input int cnt, input logic ack, input logic ovf,
                              input logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.ack = ack; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == 8));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("almostfull", 32'(almostfull), 32'((m_cnt >= int'(af_thresh)) && (m_cnt != 8)));
    chk("almostempty", 32'(almostempty), 32'((m_cnt <= int'(ae_thresh)) && (m_cnt != 0)));
  endtask

  // driver task: one clock of stimulus, then model update and comparison
  task automatic step(input logic wr, input logic rd, input logic [15:0] din);
    logic        wa;
    logic        ra;
    logic        was_empty;
    logic [15:0] popped;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    data_in = din;
    was_empty = (m_cnt == 0);
    wa = wr && ((m_cnt != 8) || rd);
    ra = rd && !was_empty;
    popped = '0;
    @(posedge clk);
    #1;
    if (ra) popped = exp_q.pop_front();
    if (wa) exp_q.push_back(din);
    m_cnt = m_cnt + int'(wa) - int'(ra);
`ifdef FIFO_FWFT_EN
    exp_dout = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
`else
    if (ra) exp_dout = popped;
`endif
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("wr_ack", 32'(wr_ack), 32'(wa));
    chk("overflow", 32'(overflow), 32'(wr && !wa));
    chk("underflow", 32'(underflow), 32'(rd && was_empty));
    chk_flags();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    exp_dout = '0;
  endtask

  task automatic chk_reset_state();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almostfull", 32'(almostfull), 32'd0);
    chk("rst_almostempty", 32'(almostempty), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    data_in = '0;
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    model_reset();
    rst = 1'b1;
    #1;
    chk_reset_state();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fill, overflow, full read+write, drain, empty read+write, underflow
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(1'b1, 1'b0, 16'(i), (i <= 8) ? i : 8, i <= 8, i == 9, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'hBEEF, 8, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 1'b1, 16'h0000, 7 - i, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 16'h00A5, 1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_wr_ack", 32'(wr_ack), 32'(tbl[i].ack));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
      chk("tbl_underflow", 32'(underflow), 32'(tbl[i].unf));
    end

    // out-of-range thresholds: neither almost flag may assert
    af_thresh = 4'd9;
    ae_thresh = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'($urandom_range(0, 65535)));
      chk("af_oor", 32'(almostfull), 32'd0);
      chk("ae_oor", 32'(almostempty), 32'd0);
    end

    // wrap-around at constant occupancy 3
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 16'($urandom_range(0, 65535)));
      chk("wrap_count", 32'(count), 32'd3);
    end

    // reset during traffic at count 5, observed before any clock edge
    step(1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 16'h2222);
    chk("pre_rst_count", 32'(count), 32'd5);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // operation resumes; one word through an empty FIFO
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
